fir_ctrl_gen: RTL and testbench

Parametrised sequencer for the FIR datapath: turns data-ready and load-coefficient requests into per-cycle register-file and ALU commands (op, src1, src2, dest) for an NTAPS-tap multiply/alternating-accumulate filter. It replaces the fixed 4-tap controller. It adds:
- a coefficient-ready interlock;
- an explicit register map derived from parameters;
- an optional queued-sample mode.

It sits between the sync/edge-detect front end and the ALU/register-file datapath.

---
 rtl/fir_ctrl_gen_pkg.sv | 52 +++++
 rtl/fir_ctrl_gen_wrap_counter.sv | 33 +++
 rtl/fir_ctrl_gen.sv | 200 ++++++++++++++++++++
 tb/tb_fir_ctrl_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_gen_pkg.sv
// fir_ctrl_pkg: shared types and register-map helpers for the FIR sequencer.
//   op_t    - ALU opcode issued on the op output
//   state_t - sequencer FSM states
//   *_base / acc_reg / temp_reg / zero_reg - register-file map as a function
//   of the tap count and register-file address width.
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_COPY  = 3'b001,
    OP_LOAD1 = 3'b010,
    OP_LOAD2 = 3'b011,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_MUL   = 3'b110
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EIDLE,
    S_LOADC,
    S_LOADD,
    S_MUL,
    S_ACC,
    S_DONE
  } state_t;

  function automatic int out_reg(input int ntaps, input int reg_aw);
    return 0;
  endfunction

  function automatic int samp_base(input int ntaps, input int reg_aw);
    return 1;
  endfunction

  function automatic int coef_base(input int ntaps, input int reg_aw);
    return ntaps + 1;
  endfunction

  function automatic int acc_reg(input int ntaps, input int reg_aw);
    return 2 * ntaps + 1;
  endfunction

  function automatic int temp_reg(input int ntaps, input int reg_aw);
    return 2 * ntaps + 2;
  endfunction

  function automatic int zero_reg(input int ntaps, input int reg_aw);
    return (1 << reg_aw) - 1;
  endfunction

endpackage

// File: rtl/fir_ctrl_gen_wrap_counter.sv
// wrap_counter: modulo-MAX counter with explicit wrap compare, so MAX need
// not be a power of two.
//   MAX   - modulus (>= 2)
//   DIR   - 0 counts up (MAX-1 -> 0), 1 counts down (0 -> MAX-1)
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset to 0
//   clr   - synchronous clear to 0
//   en    - step one position in direction DIR
//   count - current value
module wrap_counter #(
  parameter int MAX = 4,
  parameter bit DIR = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  output logic [$clog2(MAX)-1:0] count
);

  localparam int CW = $clog2(MAX);
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      if (DIR == 1'b0) count <= (count == LAST) ? '0 : count + 1'b1;
      else             count <= (count == '0)   ? LAST : count - 1'b1;
    end
  end

endmodule

// File: rtl/fir_ctrl_gen.sv
// fir_ctrl_gen: sequencer for an NTAPS-tap multiply / alternating-accumulate
// FIR datapath. Turns dr (sample ready) and lc (load coefficient) levels into
// per-cycle register-file/ALU commands.
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   dr, lc            - data-ready and load-coefficient levels
//   overflow          - ALU overflow for the op issued this cycle
//   cnt_up, clear     - pulse per accepted sample / per coefficient load
//   modwait, err      - busy (not IDLE/EIDLE) / in error idle
//   op,src1,src2,dest - ALU opcode and register indices
//   coef_ready        - NTAPS coefficients loaded since reset
// Optional build macro FIR_CTRL_DRQ_EN: one-deep queue for a sample whose dr
// rising edge arrives while a computation is in flight.
module fir_ctrl_gen
  import fir_ctrl_pkg::*;
#(
  parameter int NTAPS  = 4,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dr,
  input  logic              lc,
  input  logic              overflow,
  output logic              cnt_up,
  output logic              clear,
  output logic              modwait,
  output logic [2:0]        op,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic [REG_AW-1:0] dest,
  output logic              err,
  output logic              coef_ready
);

  if (NTAPS < 2 || (2 * NTAPS + 3) > (1 << REG_AW)) begin : g_param_check
    $error("fir_ctrl_gen: NTAPS=%0d does not fit REG_AW=%0d", NTAPS, REG_AW);
  end

  localparam int CW = $clog2(NTAPS);
  localparam int SW = CW + 1;
  localparam int KW = $clog2(NTAPS + 1);

  localparam logic [REG_AW-1:0] OUT_A  = REG_AW'(out_reg(NTAPS, REG_AW));
  localparam logic [REG_AW-1:0] SAMP_A = REG_AW'(samp_base(NTAPS, REG_AW));
  localparam logic [REG_AW-1:0] COEF_A = REG_AW'(coef_base(NTAPS, REG_AW));
  localparam logic [REG_AW-1:0] ACC_A  = REG_AW'(acc_reg(NTAPS, REG_AW));
  localparam logic [REG_AW-1:0] TEMP_A = REG_AW'(temp_reg(NTAPS, REG_AW));
  localparam logic [REG_AW-1:0] ZERO_A = REG_AW'(zero_reg(NTAPS, REG_AW));
  localparam logic [CW-1:0]     LAST_T = CW'(NTAPS - 1);

  state_t          state, nxt;
  op_t             op_c;
  logic [CW-1:0]   w, c, t, s;
  logic [KW-1:0]   cc;
  logic [SW-1:0]   st_sum, st_idx;
  logic            w_dec, c_inc, t_clr, t_inc, s_ld, pend_clr;
  logic            take;
  state_t          done_next;

  wrap_counter #(.MAX(NTAPS), .DIR(1'b1)) u_w (
    .clk(clk), .rst(rst), .clr(1'b0), .en(w_dec), .count(w));
  wrap_counter #(.MAX(NTAPS), .DIR(1'b0)) u_c (
    .clk(clk), .rst(rst), .clr(1'b0), .en(c_inc), .count(c));
  wrap_counter #(.MAX(NTAPS), .DIR(1'b0)) u_t (
    .clk(clk), .rst(rst), .clr(t_clr), .en(t_inc), .count(t));

  assign coef_ready = (cc == KW'(NTAPS));
  assign op         = op_c;

  // Slot of the tap-t sample: newest sample at s, older ones at s+1, s+2, ...
  always_comb begin
    st_sum = {1'b0, s} + {1'b0, t};
    st_idx = (st_sum >= SW'(NTAPS)) ? st_sum - SW'(NTAPS) : st_sum;
  end

`ifdef FIR_CTRL_DRQ_EN
  logic dr_q, pending, dbl, busy, rise, pend_eff, dbl_eff;

  always_comb begin
    busy     = (state == S_MUL) || (state == S_ACC) || (state == S_DONE);
    rise     = dr && !dr_q;
    pend_eff = pending || (busy && rise);
    dbl_eff  = dbl || (busy && rise && pending);
    // A queued sample is written even if dr has since dropped.
    take     = dr || pending;
    if (dbl_eff)       done_next = S_EIDLE;
    else if (pend_eff) done_next = S_LOADD;
    else               done_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dr_q    <= 1'b0;
      pending <= 1'b0;
      dbl     <= 1'b0;
    end else begin
      dr_q <= dr;
      if (nxt == S_EIDLE || pend_clr) begin
        pending <= 1'b0;
        dbl     <= 1'b0;
      end else if (busy && rise) begin
        pending <= 1'b1;
        if (pending) dbl <= 1'b1;
      end
    end
  end
`else
  always_comb begin
    take      = dr;
    done_next = S_IDLE;
  end
`endif

  always_comb begin
    nxt      = state;
    op_c     = OP_NOP;
    src1     = '0;
    src2     = '0;
    dest     = '0;
    cnt_up   = 1'b0;
    clear    = 1'b0;
    modwait  = 1'b1;
    err      = 1'b0;
    w_dec    = 1'b0;
    c_inc    = 1'b0;
    t_clr    = 1'b0;
    t_inc    = 1'b0;
    s_ld     = 1'b0;
    pend_clr = 1'b0;
    case (state)
      S_IDLE, S_EIDLE: begin
        modwait = 1'b0;
        err     = (state == S_EIDLE);
        if (dr)      nxt = coef_ready ? S_LOADD : S_EIDLE;
        else if (lc) nxt = S_LOADC;
      end
      S_LOADC: begin
        op_c  = OP_LOAD2;
        dest  = COEF_A + REG_AW'(c);
        clear = 1'b1;
        c_inc = 1'b1;
        nxt   = S_IDLE;
      end
      S_LOADD: begin
        if (take) begin
          op_c     = OP_LOAD1;
          dest     = SAMP_A + REG_AW'(w);
          cnt_up   = 1'b1;
          s_ld     = 1'b1;
          w_dec    = 1'b1;
          t_clr    = 1'b1;
          pend_clr = 1'b1;
          nxt      = S_MUL;
        end else begin
          nxt = S_EIDLE;
        end
      end
      S_MUL: begin
        op_c = OP_MUL;
        src1 = SAMP_A + REG_AW'(st_idx);
        src2 = COEF_A + REG_AW'(t);
        dest = TEMP_A;
        nxt  = overflow ? S_EIDLE : S_ACC;
      end
      S_ACC: begin
        op_c  = t[0] ? OP_SUB : OP_ADD;
        src1  = (t == '0) ? ZERO_A : ACC_A;
        src2  = TEMP_A;
        dest  = ACC_A;
        t_inc = 1'b1;
        if (overflow)         nxt = S_EIDLE;
        else if (t == LAST_T) nxt = S_DONE;
        else                  nxt = S_MUL;
      end
      S_DONE: begin
        op_c = OP_COPY;
        src1 = ACC_A;
        dest = OUT_A;
        nxt  = overflow ? S_EIDLE : done_next;
      end
      default: begin
        modwait = 1'b0;
        nxt     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      s     <= '0;
      cc    <= '0;
    end else begin
      state <= nxt;
      if (s_ld) s <= w;
      if (c_inc && !coef_ready) cc <= cc + 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_ctrl_gen.sv
// Scoreboard bench for fir_ctrl_gen (NTAPS=4, REG_AW=4). The stimulus side
// computes the full command sequence of each transaction from the register
// map and pointer arithmetic, pushing one expected output record per cycle;
// a monitor on the falling edge pops and compares.
module tb_fir_ctrl_gen;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int SB = 1;
  localparam int CB = N + 1;
  localparam int AC = 2 * N + 1;
  localparam int TM = 2 * N + 2;
  localparam int ZR = (1 << AW) - 1;

  typedef struct packed {
    logic          chk;
    logic [2:0]    op;
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    logic [AW-1:0] dest;
    logic          cnt_up;
    logic          clear;
    logic          modwait;
    logic          err;
    logic          coef_ready;
  } rec_t;

  logic clk = 1'b0, rst = 1'b0, dr = 1'b0, lc = 1'b0, overflow = 1'b0;
  logic          cnt_up, clear, modwait, err, coef_ready;
  logic [2:0]    op;
  logic [AW-1:0] src1, src2, dest;

  fir_ctrl_gen #(.NTAPS(N), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .dr(dr), .lc(lc), .overflow(overflow),
    .cnt_up(cnt_up), .clear(clear), .modwait(modwait), .op(op),
    .src1(src1), .src2(src2), .dest(dest), .err(err), .coef_ready(coef_ready));

  always #5 clk = ~clk;

  rec_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: pointers as plain integers.
  int w = 0, c = 0, cc = 0;
  bit in_err = 1'b0;

  rec_t mexp, mgot;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mexp = expq.pop_front();
      if (mexp.chk) begin
        mgot = '{1'b1, op, src1, src2, dest, cnt_up, clear, modwait, err, coef_ready};
        n_checks++;
        if (mgot !== mexp) begin
          n_fail++;
          $display("FAIL cmd @%0t: got op=%0d src1=%0d src2=%0d dest=%0d cnt_up=%b clear=%b modwait=%b err=%b coef_ready=%b | want op=%0d src1=%0d src2=%0d dest=%0d cnt_up=%b clear=%b modwait=%b err=%b coef_ready=%b",
                   $time, mgot.op, mgot.src1, mgot.src2, mgot.dest, mgot.cnt_up, mgot.clear,
                   mgot.modwait, mgot.err, mgot.coef_ready, mexp.op, mexp.src1, mexp.src2,
                   mexp.dest, mexp.cnt_up, mexp.clear, mexp.modwait, mexp.err, mexp.coef_ready);
        end
      end
    end
  end

  function automatic bit rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic rec_t idle_rec();
    rec_t r = '0;
    r.chk        = 1'b1;
    r.err        = in_err;
    r.coef_ready = (cc >= N);
    return r;
  endfunction

  function automatic rec_t busy_rec(input int o, input int s1, input int s2, input int d);
    rec_t r = '0;
    r.chk        = 1'b1;
    r.modwait    = 1'b1;
    r.coef_ready = (cc >= N);
    r.op         = 3'(o);
    r.src1       = AW'(s1);
    r.src2       = AW'(s2);
    r.dest       = AW'(d);
    return r;
  endfunction

  function automatic void model_reset();
    w = 0; c = 0; cc = 0; in_err = 1'b0;
  endfunction

  task automatic drive(input bit d, input bit l, input bit o, input bit r, input rec_t e);
    @(posedge clk);
    #1;
    dr = d; lc = l; overflow = o; rst = r;
    expq.push_back(e);
  endtask

  task automatic do_reset();
    rec_t e = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, e);
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, idle_rec());
  endtask

  task automatic idle_cyc();
    drive(1'b0, 1'b0, rb(), 1'b0, idle_rec());
  endtask

  task automatic load_coef();
    rec_t e;
    drive(1'b0, 1'b1, rb(), 1'b0, idle_rec());
    e = busy_rec(3, 0, 0, CB + c);
    e.clear = 1'b1;
    drive(rb(), rb(), rb(), 1'b0, e);
    c = (c + 1) % N;
    if (cc < N) cc++;
    in_err = 1'b0;
  endtask

  // One sample: step k of the computation is MUL (even k), ACC (odd k) or
  // COPY (k == 2N). ovf_at/rst_at inject overflow/reset at that step.
  task automatic sample(input int ovf_at, input bit drop, input int rst_at,
                        input bit redge, input bit skip_idle);
    rec_t e;
    int   s, t;
    if (!skip_idle) begin
      drive(1'b1, rb(), rb(), 1'b0, idle_rec());
      if (cc < N) begin
        in_err = 1'b1;
        return;
      end
    end
    if (drop) begin
      drive(1'b0, rb(), rb(), 1'b0, busy_rec(0, 0, 0, 0));
      in_err = 1'b1;
      return;
    end
    e = busy_rec(2, 0, 0, SB + w);
    e.cnt_up = 1'b1;
    drive(1'b1, rb(), rb(), 1'b0, e);
    s = w;
    w = (w + N - 1) % N;
    for (int k = 0; k <= 2 * N; k++) begin
      t = k / 2;
      if (k == 2 * N)      e = busy_rec(1, AC, 0, 0);
      else if (k % 2 == 0) e = busy_rec(6, SB + (s + t) % N, CB + t, TM);
      else                 e = busy_rec((t % 2) ? 5 : 4, (t == 0) ? ZR : AC, TM, AC);
      drive(redge && k >= 1, rb(), (k == ovf_at), (k == rst_at), e);
      if (k == rst_at) begin
        model_reset();
        return;
      end
      if (k == ovf_at) begin
        in_err = 1'b1;
        return;
      end
    end
    in_err = 1'b0;
  endtask

  // Sample whose dr rises again during ACC and stays high, then the follow-on.
  task automatic back_to_back();
    sample(-1, 1'b0, -1, 1'b1, 1'b0);
`ifdef FIR_CTRL_DRQ_EN
    sample(-1, 1'b0, -1, 1'b0, 1'b1);
`else
    sample(-1, 1'b0, -1, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    int r, ovf, rs;
    bit dp;
    do_reset();
    idle_cyc();
    // dr without coefficients -> error idle, err holds
    sample(-1, 1'b0, -1, 1'b0, 1'b0);
    idle_cyc();
    idle_cyc();
    // four coefficient loads, first one leaves EIDLE
    for (int i = 0; i < N; i++) load_coef();
    idle_cyc();
    sample(-1, 1'b0, -1, 1'b0, 1'b0);
    sample(-1, 1'b0, -1, 1'b0, 1'b0);
    // overflow on the third MUL
    sample(4, 1'b0, -1, 1'b0, 1'b0);
    idle_cyc();
    sample(-1, 1'b0, -1, 1'b0, 1'b0);
    // dr drops in LOADD
    sample(-1, 1'b1, -1, 1'b0, 1'b0);
    idle_cyc();
    // overflow during COPY
    sample(2 * N, 1'b0, -1, 1'b0, 1'b0);
    back_to_back();
    // fifth load wraps onto the first coefficient slot
    load_coef();
    // reset in the middle of a computation
    sample(-1, 1'b0, 5, 1'b0, 1'b0);
    idle_cyc();
    for (int i = 0; i < N; i++) load_coef();

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99, 0);
      if (r < 20) begin
        idle_cyc();
      end else if (r < 40) begin
        load_coef();
      end else if (r < 48 && cc >= N) begin
        back_to_back();
      end else begin
        ovf = ($urandom_range(3, 0) == 0) ? $urandom_range(2 * N, 0) : -1;
        rs  = ($urandom_range(24, 0) == 0) ? $urandom_range(2 * N, 0) : -1;
        dp  = ($urandom_range(11, 0) == 0);
        sample(ovf, dp, rs, 1'b0, 1'b0);
      end
    end
    idle_cyc();
    idle_cyc();
    @(negedge clk);
    #1;
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d records left, want 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
